// File: rtl/silencer_scheduler.sv
// Per-period burst sequencer feeding the silencer intensity interpolator.
// Reads DEPTH samples per trigger, then waits for the interpolator pipeline to drain.
module silencer_scheduler #(
    parameter int DEPTH = 249,
    parameter int GUARD = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TRIG,
    input  logic [15:0] CFG_UPDATE_RATE,
    input  logic        CFG_ENABLE,
    input  logic        CFG_SET,
    output logic [7:0]  ADDR,
    input  logic [15:0] RDATA,
    output logic        START,
    output logic [15:0] INTENSITY_OUT,
    output logic        DOUT_VALID,
    output logic [15:0] UPDATE_RATE,
    output logic        BUSY,
    output logic [7:0]  OVERRUN_CNT
);

    localparam int CW = $clog2(GUARD + 2);
    localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_GUARD
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic [7:0]  ovr_q, ovr_d;
    logic [15:0] stg_rate_q, stg_rate_d;
    logic        stg_en_q, stg_en_d;
    logic [15:0] act_rate_q, act_rate_d;
    logic        act_en_q, act_en_d;
    logic        start_q, start_d;
    logic        v1_q, v1_d;
    logic        v2_q, v2_d;
    logic [15:0] int_q, int_d;
    logic        busy;

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        addr_d     = 8'd0;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        ovr_d      = ovr_q;
        stg_rate_d = stg_rate_q;
        stg_en_d   = stg_en_q;
        act_rate_d = act_rate_q;
        act_en_d   = act_en_q;
        start_d    = (state_q == S_ISSUE) && (addr_q == 8'd0);
        v1_d       = (state_q == S_ISSUE);
        v2_d       = v1_q;
        int_d      = v1_q ? RDATA : int_q;

        if (CFG_SET) begin
            stg_rate_d = CFG_UPDATE_RATE;
            stg_en_d   = CFG_ENABLE;
        end

        // One-deep trigger queue; further triggers while queued are dropped
        if (TRIG && busy) begin
            if (pending_q) begin
                if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
            end else begin
                pending_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (TRIG || pending_q) begin
                    state_d    = S_ISSUE;
                    pending_d  = 1'b0;
                    act_rate_d = stg_rate_q;
                    act_en_d   = stg_en_q;
                end
            end
            S_ISSUE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    addr_d = addr_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            addr_q     <= 8'd0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            ovr_q      <= 8'd0;
            stg_rate_q <= 16'd0;
            stg_en_q   <= 1'b0;
            act_rate_q <= 16'd0;
            act_en_q   <= 1'b0;
            start_q    <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            int_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            ovr_q      <= ovr_d;
            stg_rate_q <= stg_rate_d;
            stg_en_q   <= stg_en_d;
            act_rate_q <= act_rate_d;
            act_en_q   <= act_en_d;
            start_q    <= start_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            int_q      <= int_d;
        end
    end

    assign ADDR          = addr_q;
    assign START         = start_q;
    assign INTENSITY_OUT = int_q;
    assign DOUT_VALID    = v2_q;
    assign UPDATE_RATE   = act_en_q ? act_rate_q : 16'hFFFF;
    assign BUSY          = busy;
    assign OVERRUN_CNT   = ovr_q;

endmodule

// File: tb/tb_silencer_scheduler.sv
// Directed bench: a DEPTH=4 instance and a DEPTH=249 instance, each with a registered-read memory.
module tb_silencer_scheduler;

    logic        clk = 1'b0;
    logic [15:0] cfg_rate = 16'd0;
    logic        cfg_en = 1'b0;
    logic        cfg_set = 1'b0;

    logic        rst_a = 1'b1, trig_a = 1'b0;
    logic [7:0]  addr_a, ovr_a;
    logic [15:0] rdata_a, int_a, ur_a;
    logic        start_a, dv_a, busy_a;

    logic        rst_b = 1'b1, trig_b = 1'b0;
    logic [7:0]  addr_b, ovr_b;
    logic [15:0] rdata_b, int_b, ur_b;
    logic        start_b, dv_b, busy_b;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rdata_a <= mem_a[addr_a];
    always @(posedge clk) rdata_b <= mem_b[addr_b];

    silencer_scheduler #(.DEPTH(4), .GUARD(8)) u_a (
        .CLK(clk), .RST(rst_a), .TRIG(trig_a),
        .CFG_UPDATE_RATE(cfg_rate), .CFG_ENABLE(cfg_en), .CFG_SET(cfg_set),
        .ADDR(addr_a), .RDATA(rdata_a), .START(start_a),
        .INTENSITY_OUT(int_a), .DOUT_VALID(dv_a), .UPDATE_RATE(ur_a),
        .BUSY(busy_a), .OVERRUN_CNT(ovr_a)
    );

    silencer_scheduler #(.DEPTH(249), .GUARD(8)) u_b (
        .CLK(clk), .RST(rst_b), .TRIG(trig_b),
        .CFG_UPDATE_RATE(cfg_rate), .CFG_ENABLE(cfg_en), .CFG_SET(cfg_set),
        .ADDR(addr_b), .RDATA(rdata_b), .START(start_b),
        .INTENSITY_OUT(int_b), .DOUT_VALID(dv_b), .UPDATE_RATE(ur_b),
        .BUSY(busy_b), .OVERRUN_CNT(ovr_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_idle_a: busy=%b required 0 within 100 cycles", busy_a);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'(i * 3);
            mem_b[i] = 16'($urandom);
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();
        n_cmp += 7;
        if (addr_a !== 8'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 00", addr_a); end
        if (start_a !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b want 0", start_a); end
        if (int_a !== 16'd0) begin n_bad++; $display("FAIL rst_int: got %h want 0000", int_a); end
        if (dv_a !== 1'b0) begin n_bad++; $display("FAIL rst_dv: got %b want 0", dv_a); end
        if (ur_a !== 16'hFFFF) begin n_bad++; $display("FAIL rst_ur: got %h want ffff", ur_a); end
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        if (ovr_a !== 8'd0) begin n_bad++; $display("FAIL rst_ovr: got %h want 00", ovr_a); end
    endtask

    task automatic test_single_burst();
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        for (int off = 1; off <= 16; off++) begin
            logic       e_st, e_dv, e_bz;
            logic [7:0] e_ad;
            e_st = (off == 2);
            e_dv = (off >= 3 && off <= 6);
            e_bz = (off >= 1 && off <= 14);
            e_ad = (off <= 4) ? 8'(off - 1) : 8'd0;
            n_cmp += 4;
            if (start_a !== e_st) begin n_bad++; $display("FAIL burst_start k+%0d: got %b want %b", off, start_a, e_st); end
            if (dv_a !== e_dv) begin n_bad++; $display("FAIL burst_dv k+%0d: got %b want %b", off, dv_a, e_dv); end
            if (busy_a !== e_bz) begin n_bad++; $display("FAIL burst_busy k+%0d: got %b want %b", off, busy_a, e_bz); end
            if (addr_a !== e_ad) begin n_bad++; $display("FAIL burst_addr k+%0d: got %h want %h", off, addr_a, e_ad); end
            if (e_dv) begin
                n_cmp++;
                if (int_a !== 16'((off - 3) * 3)) begin
                    n_bad++;
                    $display("FAIL burst_data k+%0d: got %0d want %0d", off, int_a, (off - 3) * 3);
                end
            end
            step();
        end
    endtask

    task automatic test_config();
        cfg_rate = 16'h0040;
        cfg_en = 1'b1;
        cfg_set = 1'b1;
        step();
        cfg_set = 1'b0;
        step();
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        n_cmp++;
        if (ur_a !== 16'h0040) begin n_bad++; $display("FAIL cfg_first: got %h want 0040", ur_a); end
        step();
        step();
        cfg_rate = 16'h0010;
        cfg_set = 1'b1;
        step();
        cfg_set = 1'b0;
        n_cmp++;
        if (ur_a !== 16'h0040) begin n_bad++; $display("FAIL cfg_hold: got %h want 0040", ur_a); end
        wait_idle_a();
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        n_cmp++;
        if (ur_a !== 16'h0010) begin n_bad++; $display("FAIL cfg_next: got %h want 0010", ur_a); end
        cfg_en = 1'b0;
        cfg_set = 1'b1;
        step();
        cfg_set = 1'b0;
        n_cmp++;
        if (ur_a !== 16'h0010) begin n_bad++; $display("FAIL cfg_hold2: got %h want 0010", ur_a); end
        wait_idle_a();
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        n_cmp++;
        if (ur_a !== 16'hFFFF) begin n_bad++; $display("FAIL cfg_disable: got %h want ffff", ur_a); end
        wait_idle_a();
    endtask

    task automatic test_pending();
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        step();
        trig_a = 1'b1;
        step();
        step();
        trig_a = 1'b0;
        n_cmp++;
        if (ovr_a !== 8'd1) begin n_bad++; $display("FAIL pend_ovr: got %0d want 1", ovr_a); end
        repeat (11) step();
        n_cmp++;
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL pend_idle k+15: busy got %b want 0", busy_a); end
        step();
        n_cmp += 2;
        if (busy_a !== 1'b1) begin n_bad++; $display("FAIL pend_reissue k+16: busy got %b want 1", busy_a); end
        if (start_a !== 1'b0) begin n_bad++; $display("FAIL pend_nostart k+16: got %b want 0", start_a); end
        step();
        n_cmp++;
        if (start_a !== 1'b1) begin n_bad++; $display("FAIL pend_start k+17: got %b want 1", start_a); end
        wait_idle_a();
        trig_a = 1'b1;
        repeat (400) step();
        trig_a = 1'b0;
        step();
        n_cmp++;
        if (ovr_a !== 8'd255) begin n_bad++; $display("FAIL ovr_sat: got %0d want 255", ovr_a); end
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        n_cmp++;
        if (ovr_a !== 8'd0) begin n_bad++; $display("FAIL ovr_clear: got %0d want 0", ovr_a); end
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        cfg_rate = 16'h0040;
        cfg_en = 1'b1;
        cfg_set = 1'b1;
        step();
        cfg_set = 1'b0;
        trig_b = 1'b1;
        step();
        step();
        step();
        trig_b = 1'b0;
        n_cmp += 2;
        if (ovr_b !== 8'd1) begin n_bad++; $display("FAIL mid_ovr k+3: got %0d want 1", ovr_b); end
        if (ur_b !== 16'h0040) begin n_bad++; $display("FAIL mid_ur k+3: got %h want 0040", ur_b); end
        step();
        step();
        n_cmp++;
        if (dv_b !== 1'b1) begin n_bad++; $display("FAIL mid_dv k+5: got %b want 1", dv_b); end
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        n_cmp += 5;
        if (dv_b !== 1'b0) begin n_bad++; $display("FAIL mid_rst_dv: got %b want 0", dv_b); end
        if (busy_b !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy_b); end
        if (ovr_b !== 8'd0) begin n_bad++; $display("FAIL mid_rst_ovr: got %0d want 0", ovr_b); end
        if (ur_b !== 16'hFFFF) begin n_bad++; $display("FAIL mid_rst_ur: got %h want ffff", ur_b); end
        if (addr_b !== 8'd0) begin n_bad++; $display("FAIL mid_rst_addr: got %h want 00", addr_b); end
        for (int i = 0; i < 300; i++) begin
            step();
            if (start_b !== 1'b0 || busy_b !== 1'b0 || dv_b !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin n_bad++; $display("FAIL mid_quiet: activity seen want none after reset"); end
    endtask

    task automatic test_full_depth();
        int n_valid = 0;
        int max_addr = 0;
        bit seq_bad = 1'b0;
        trig_b = 1'b1;
        step();
        trig_b = 1'b0;
        for (int off = 1; off <= 270; off++) begin
            logic e_dv;
            if (int'(addr_b) > max_addr) max_addr = int'(addr_b);
            e_dv = (off >= 3 && off <= 251);
            if (off == 2) begin
                n_cmp++;
                if (start_b !== 1'b1) begin n_bad++; $display("FAIL full_start: got %b want 1", start_b); end
            end
            if (dv_b !== e_dv) seq_bad = 1'b1;
            if (dv_b === 1'b1) begin
                n_valid++;
                n_cmp++;
                if (off >= 3 && int_b !== mem_b[off - 3]) begin
                    n_bad++;
                    $display("FAIL full_data k+%0d: got %h want %h", off, int_b, mem_b[off - 3]);
                end
            end
            step();
        end
        n_cmp += 3;
        if (n_valid != 249) begin n_bad++; $display("FAIL full_count: got %0d want 249", n_valid); end
        if (seq_bad) begin n_bad++; $display("FAIL full_window: valid not exactly k+3..k+251"); end
        if (max_addr > 248) begin n_bad++; $display("FAIL full_addr: max %0d want <=248", max_addr); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_config();
        test_pending();
        test_reset_mid();
        test_full_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
